// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and the instruction memory (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues word fetches over a req/ready bus and feeds the IF/ID register.
// A one-entry skid buffer absorbs a word returned during a stall; a redirect with a pending request drains it first.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            NextPCSrc_in,
  input  logic [31:0]     branch_target_in,
  if_fetch_unit_if.master imem,
  output logic [31:0]     instruction_out,
  output logic [31:0]     pc_out_out,
  output logic [31:0]     sum_out_out,
  output logic            valid_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] sum;
    logic        valid;
  } fetch_out_t;

  localparam fetch_out_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, sum: 32'h0, valid: 1'b0};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  fetch_out_t   out_q, out_d;
  logic         started_q;

  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         req;
  logic         granted;

  assign target   = branch_target_in & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;
  assign granted  = req && imem.imem_ready;

  // started_q delays the first request until the edge after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 32'h0;
      redirect_pc_q <= RESET_PC;
      out_q         <= BUBBLE;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      redirect_pc_q <= redirect_pc_d;
      out_q         <= out_d;
      started_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    redirect_pc_d = redirect_pc_q;
    out_d         = out_q;

    case (state_q)
      FETCH: begin
        if (NextPCSrc_in) begin
          out_d = BUBBLE;
          if (req && !imem.imem_ready) begin
            redirect_pc_d = target;
            state_d       = DRAIN;
          end else begin
            pc_d = target;
          end
        end else if (granted) begin
          pc_d = pc_plus4;
          if (stall_in) begin
            hold_instr_d = imem.imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            out_d = '{instr: imem.imem_rdata, pc: pc_q, sum: pc_plus4, valid: 1'b1};
          end
        end else if (!stall_in) begin
          out_d = BUBBLE;
        end
      end

      HOLD: begin
        if (NextPCSrc_in) begin
          out_d   = BUBBLE;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_in) begin
          out_d   = '{instr: hold_instr_q, pc: hold_pc_q, sum: hold_pc_q + 32'd4, valid: 1'b1};
          state_d = FETCH;
        end
      end

      DRAIN: begin
        // The outstanding response is thrown away; the most recent redirect target wins.
        if (NextPCSrc_in) begin
          redirect_pc_d = target;
        end
        if (granted) begin
          pc_d    = NextPCSrc_in ? target : redirect_pc_q;
          state_d = FETCH;
        end
        if (NextPCSrc_in || !stall_in) begin
          out_d = BUBBLE;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    req            = started_q && !rst && (state_q != HOLD);
    imem.imem_req  = req;
    imem.imem_addr = pc_q;
  end

  assign instruction_out = out_q.instr;
  assign pc_out_out      = out_q.pc;
  assign sum_out_out     = out_q.sum;
  assign valid_out       = out_q.valid;

  // A request left waiting must keep its address until the memory accepts it.
  property p_addr_stable;
    @(posedge clk) disable iff (rst)
      (imem.imem_req && !imem.imem_ready) |=> $stable(imem.imem_addr);
  endproperty
  a_addr_stable: assert property (p_addr_stable);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a scoreboard queue of hand-computed instructions checked by a monitor thread.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0033;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        next_pc_src;
  logic [31:0] branch_target;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] sum_out;
  logic        valid_out;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  int   wait_cycles;
  int   grant_limit;
  int   grants_issued = 0;
  int   wait_cnt = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .NextPCSrc_in    (next_pc_src),
    .branch_target_in(branch_target),
    .imem            (bus),
    .instruction_out (instruction_out),
    .pc_out_out      (pc_out),
    .sum_out_out     (sum_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  // Memory answers addr^MEM_KEY after wait_cycles, and only while grants remain below grant_limit.
  assign bus.imem_ready = bus.imem_req && (wait_cnt >= wait_cycles) && (grants_issued < grant_limit);
  assign bus.imem_rdata = bus.imem_addr ^ MEM_KEY;

  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_ready) begin
      grants_issued <= grants_issued + 1;
      wait_cnt      <= 0;
    end else if (bus.imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] target);
    stall_in      = stall;
    next_pc_src   = redirect;
    branch_target = target;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] sum);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.sum   = sum;
    exp_q.push_back(e);
  endtask

  // A new word is on the outputs only if stall was low at the preceding rising edge.
  task automatic monitorLoop();
    exp_t e;
    logic cap_stall;
    forever begin
      @(posedge clk);
      cap_stall = stall_in;
      @(negedge clk);
      if (!cap_stall && valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_valid: got pc %h, expected no instruction", pc_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_instr", instruction_out, e.instr);
          checkOutput("sb_pc", pc_out, e.pc);
          checkOutput("sb_sum", sum_out, e.sum);
        end
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    checkOutput("rst_valid", {31'h0, valid_out}, 32'h0);
    checkOutput("rst_instr", instruction_out, NOP);
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_sum", sum_out, 32'h0);
    checkOutput("rst_req", {31'h0, bus.imem_req}, 32'h0);
    tick(1);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    tick(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s: got %0d words pending, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    wait_cycles = 0;
    grant_limit = 0;
    fork
      monitorLoop();
    join_none

    $display("[TB] phase 1: zero-wait streaming");
    doReset();
    wait_cycles = 0;
    grant_limit = grants_issued + 4;
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_0004, 32'h0000_0004, 32'h0000_0008);
    pushExp(32'hA5A5_0008, 32'h0000_0008, 32'h0000_000C);
    pushExp(32'hA5A5_000C, 32'h0000_000C, 32'h0000_0010);
    tick(1);
    @(negedge clk);
    checkOutput("p1_req", {31'h0, bus.imem_req}, 32'h1);
    checkOutput("p1_addr0", bus.imem_addr, 32'h0);
    checkOutput("p1_first_bubble", {31'h0, valid_out}, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p1_addr4", bus.imem_addr, 32'h4);
    tick(1);
    @(negedge clk);
    checkOutput("p1_addr8", bus.imem_addr, 32'h8);
    tick(1);
    @(negedge clk);
    checkOutput("p1_addrC", bus.imem_addr, 32'hC);
    waitDrain("p1_drain");

    $display("[TB] phase 2: two wait cycles");
    doReset();
    wait_cycles = 2;
    grant_limit = grants_issued + 3;
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_0004, 32'h0000_0004, 32'h0000_0008);
    pushExp(32'hA5A5_0008, 32'h0000_0008, 32'h0000_000C);
    tick(1);
    @(negedge clk);
    checkOutput("p2_addr_w0", bus.imem_addr, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p2_addr_w1", bus.imem_addr, 32'h0);
    checkOutput("p2_bubble_w1", {31'h0, valid_out}, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p2_addr_w2", bus.imem_addr, 32'h0);
    checkOutput("p2_bubble_w2", {31'h0, valid_out}, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p2_addr_next", bus.imem_addr, 32'h4);
    waitDrain("p2_drain");

    $display("[TB] phase 3: stall into HOLD");
    doReset();
    wait_cycles = 0;
    grant_limit = grants_issued + 4;
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_0004, 32'h0000_0004, 32'h0000_0008);
    pushExp(32'hA5A5_0008, 32'h0000_0008, 32'h0000_000C);
    pushExp(32'hA5A5_000C, 32'h0000_000C, 32'h0000_0010);
    tick(3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p3_hold_req", {31'h0, bus.imem_req}, 32'h0);
    checkOutput("p3_hold_pc", pc_out, 32'h4);
    tick(1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("p3_release_req", {31'h0, bus.imem_req}, 32'h0);
    checkOutput("p3_release_pc", pc_out, 32'h4);
    tick(1);
    @(negedge clk);
    checkOutput("p3_buffered_pc", pc_out, 32'h8);
    checkOutput("p3_resume_addr", bus.imem_addr, 32'hC);
    waitDrain("p3_drain");

    $display("[TB] phase 4: redirect during pending fetch");
    doReset();
    wait_cycles = 0;
    grant_limit = grants_issued + 4;
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_0004, 32'h0000_0004, 32'h0000_0008);
    pushExp(32'hA5A5_0008, 32'h0000_0008, 32'h0000_000C);
    pushExp(32'hA5A5_000C, 32'h0000_000C, 32'h0000_0010);
    pushExp(32'hA5A5_0100, 32'h0000_0100, 32'h0000_0104);
    pushExp(32'hA5A5_0104, 32'h0000_0104, 32'h0000_0108);
    tick(5);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    @(negedge clk);
    checkOutput("p4_wait_addr", bus.imem_addr, 32'h10);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    grant_limit = grants_issued + 3;
    @(negedge clk);
    checkOutput("p4_drain_addr", bus.imem_addr, 32'h10);
    checkOutput("p4_drain_bubble", {31'h0, valid_out}, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p4_target_addr", bus.imem_addr, 32'h100);
    checkOutput("p4_target_bubble", {31'h0, valid_out}, 32'h0);
    waitDrain("p4_drain");

    $display("[TB] phase 5: redirect and stall in HOLD");
    doReset();
    wait_cycles = 0;
    grant_limit = grants_issued + 3;
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_0040, 32'h0000_0040, 32'h0000_0044);
    tick(2);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0040);
    @(negedge clk);
    checkOutput("p5_hold_req", {31'h0, bus.imem_req}, 32'h0);
    checkOutput("p5_hold_pc", pc_out, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("p5_forced_bubble", {31'h0, valid_out}, 32'h0);
    checkOutput("p5_bubble_instr", instruction_out, NOP);
    checkOutput("p5_target_addr", bus.imem_addr, 32'h40);
    waitDrain("p5_drain");

    $display("[TB] phase 6: last redirect wins, PC wrap");
    doReset();
    wait_cycles = 0;
    grant_limit = grants_issued;
    pushExp(32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    tick(1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200);
    @(negedge clk);
    checkOutput("p6_first_addr", bus.imem_addr, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("p6_drain_addr", bus.imem_addr, 32'h0);
    checkOutput("p6_drain_bubble", {31'h0, valid_out}, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    grant_limit = grants_issued + 3;
    tick(1);
    @(negedge clk);
    checkOutput("p6_last_target", bus.imem_addr, 32'hFFFF_FFFC);
    tick(1);
    @(negedge clk);
    checkOutput("p6_wrap_addr", bus.imem_addr, 32'h0);
    checkOutput("p6_wrap_sum", sum_out, 32'h0);
    waitDrain("p6_drain");

    $display("[TB] phase 7: reset during DRAIN");
    doReset();
    wait_cycles = 0;
    grant_limit = grants_issued;
    pushExp(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_0004, 32'h0000_0004, 32'h0000_0008);
    tick(1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    grant_limit = grants_issued + 2;
    @(negedge clk);
    checkOutput("p7_req_in_rst", {31'h0, bus.imem_req}, 32'h0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("p7_post_rst_bubble", {31'h0, valid_out}, 32'h0);
    tick(1);
    @(negedge clk);
    checkOutput("p7_restart_req", {31'h0, bus.imem_req}, 32'h1);
    checkOutput("p7_restart_addr", bus.imem_addr, RESET_PC);
    waitDrain("p7_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage RISC-V pipeline. Holds the program counter and computes PC+4. Issues word requests to the instruction memory over a request/ready handshake and delivers `instruction`, `pc` and `pc+4` to the IF/ID register, which samples them on the falling clock edge. Branch/jump redirects (`NextPCSrc_in`) and hazard stalls are handled here, and an in-flight memory request is never abandoned.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `NOP_INSTR`, default 32'h0000_0033 (add x0,x0,x0): instruction driven on a bubble.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset rst, synchronous, active-high.
- `stall_in` input 1: hazard unit freeze; outputs hold, PC does not advance past a buffered word.
- `NextPCSrc_in` input 1: redirect request from EX; take `branch_target_in`.
- `branch_target_in` input 32: redirect target; bits [1:0] ignored (forced 0).
- `imem_req` output 1: request valid.
- `imem_addr` output 32: word address (byte-addressed, [1:0]=0); stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` input 1: response in this cycle; `imem_rdata` valid only when `imem_req`=1 and `imem_ready`=1.
- `imem_rdata` input 32: fetched instruction.
- `instruction_out` output 32: to IF/ID `instruction_in`.
- `pc_out_out` output 32: PC of `instruction_out`.
- `sum_out_out` output 32: `pc_out_out`+4.
- `valid_out` output 1: 1 = real instruction, 0 = bubble.

## Operation
- State registers: `pc`, `state` ∈ {FETCH, HOLD, DRAIN}, `hold_instr`/`hold_pc` (one-entry skid buffer), `redirect_pc`.
- Bubble: `instruction_out`=NOP_INSTR, `pc_out_out`=0, `sum_out_out`=0, `valid_out`=0.
- Output registers change only when `stall_in`=0, with one exception: a redirect forces a bubble even when stalled.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - Redirect with ready in the same cycle: drop `imem_rdata`, `pc`<=target, stay in FETCH.
  - Redirect without ready: `redirect_pc`<=target, go to DRAIN.
  - Ready, no stall: outputs <= {rdata, pc, pc+4, valid=1}, `pc`<=pc+4.
  - Ready while stalled: buffer <= {rdata, pc}, `pc`<=pc+4, go to HOLD.
  - No ready and no stall: outputs <= bubble.
- HOLD: `imem_req`=0.
  - Redirect: discard buffer, `pc`<=target, go to FETCH.
  - `stall_in`=0: outputs <= buffer (valid=1), go to FETCH.
  - Otherwise remain in HOLD.
- DRAIN: `imem_req`=1, `imem_addr`=old `pc` (held).
  - A new redirect overwrites `redirect_pc`; the last target wins.
  - On ready: discard data, `pc`<=`redirect_pc`, go to FETCH.
  - Outputs are a bubble whenever `stall_in`=0.
- Priority: `rst` > `NextPCSrc_in` > `stall_in` > normal fetch.
- Arithmetic: PC+4 is mod 2^32, so 32'hFFFF_FFFC+4 = 0. No misalignment trap.

## Timing
- Reset (rst=1 at an edge): `pc`=RESET_PC, state=FETCH, outputs=bubble, `imem_req`=0 while rst is high.
- First edge after rst falls: `imem_req`=1, `imem_addr`=RESET_PC.
- Zero-wait memory (ready same cycle): one instruction per cycle. The fetched word appears on the outputs at the rising edge that ends its request cycle, so latency from request to output is 1 cycle. IF/ID captures it on the following falling edge.
- Redirect without a pending request: the first request to the target is issued in the cycle after `NextPCSrc_in`.
- Redirect with a pending request: the request to the target follows the drained response by 1 cycle.
- Stall deasserts in HOLD: the buffered word appears on the outputs at the next edge, and the fetch at `pc` resumes in the same cycle.
- Reset mid-DRAIN or mid-HOLD: state is discarded and the next request goes to RESET_PC. Any late `imem_ready` is ignored because `imem_req`=0.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_0000: `imem_addr` runs 0,4,8,C. Outputs are bubble on the first edge, then pc_out 0,4,8 with sum 4,8,C and valid=1.
- Memory with 2 wait cycles: each word is preceded by 2 bubble cycles and `imem_addr` is stable across the waits. No word is duplicated or skipped.
- `stall_in` high for 3 cycles while the word at 8 returns: state goes to HOLD and `imem_req`=0. Outputs hold the word at 4. One edge after the stall drops the outputs show pc 8, then pc C follows.
- `NextPCSrc_in` with target 0x100 during a wait-state fetch of 0x10: the 0x10 data is discarded, the next `imem_addr`=0x100, outputs are bubbles, and the first valid output has pc 0x100.
- Redirect and stall together in HOLD with target 0x40: the buffer is dropped, a bubble is driven despite the stall, and the next request goes to 0x40.
- `pc`=0xFFFF_FFFC: `sum_out_out`=0 and the next `imem_addr`=0. Asserting rst during DRAIN gives a bubble and a next request at RESET_PC.
